// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the 4-bit ALU bitwise datapath front end.
//   - Opcode encodings for the bitwise units (OP_AND .. OP_NAND). Codes 101..111
//     are illegal.
//   - FSM state encoding used by alu_op_sequencer. It is also exported on the
//     sequencer's dbg_state port.
package alu_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'b000;
   localparam logic [OP_W-1:0] OP_OR   = 3'b001;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
   localparam logic [OP_W-1:0] OP_NOT  = 3'b011;
   localparam logic [OP_W-1:0] OP_NAND = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_bitwise_core.sv
// alu_bitwise_core
//   Purely combinational bitwise unit. It takes two operands and an opcode and
//   produces the result plus an illegal-opcode flag. It has no state; the
//   sequencer feeds it from its operand registers so the inputs stay stable.
// Ports
//   a, b  in   WIDTH  operands (b is unused for NOT)
//   op    in   3      opcode (alu_pkg encodings)
//   res   out  WIDTH  bitwise result (0 for an illegal opcode)
//   err   out  1      opcode is illegal
module alu_bitwise_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] res,
   output logic             err
);

   always_comb begin
      res = '0;
      err = 1'b0;
      case (op)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_NOT:  res = ~a;
         OP_NAND: res = ~(a & b);
         default: err = 1'b1;  // illegal opcode: the result stays 0
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Front-end sequencer for the bitwise ALU datapath.
//   It accepts a request over a valid/ready handshake and latches the operands.
//   It spends one cycle in EXEC, then registers the result and flags. It then
//   holds the result in DONE until the consumer takes it.
// Handshake rule (both sides): a transfer happens on a rising edge where valid and
//   ready are both high. A source keeps valid and its data stable until that edge.
//   in_ready is combinational from state and out_ready, so a new request can be
//   accepted on the same edge that hands off the previous result.
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     in   request valid          in_ready   out  request can be accepted
//   in_a, in_b   in   operands               in_op      in   opcode
//   out_valid    out  result valid           out_ready  in   consumer accepts result
//   out_res      out  result                 out_zero   out  out_res == 0
//   out_err      out  illegal opcode         op_count   out  completed handoffs (wraps)
//   dbg_state    out  current FSM state
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [OP_W-1:0]  in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_zero,
   output logic             out_err,
   output logic [CNT_W-1:0] op_count,
   output state_t           dbg_state
);

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [OP_W-1:0]  op_q;
   logic [WIDTH-1:0] res_q;
   logic             zero_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH-1:0] core_res;
   logic             core_err;

   alu_bitwise_core #(.WIDTH(WIDTH)) u_core (
      .a   (a_q),
      .b   (b_q),
      .op  (op_q),
      .res (core_res),
      .err (core_err)
   );

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign out_valid = (state_q == DONE);
   assign out_res   = res_q;
   assign out_zero  = zero_q;
   assign out_err   = err_q;
   assign op_count  = cnt_q;
   assign dbg_state = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // The count wraps naturally. Illegal-op results are counted as well.
         if (out_valid && out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= in_a;
                  b_q     <= in_b;
                  op_q    <= in_op;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               res_q   <= core_res;
               zero_q  <= (core_res == '0);
               err_q   <= core_err;
               state_q <= DONE;
            end
            DONE: begin
               // The result registers are not touched here. The outputs stay
               // stable while the consumer stalls, and afterwards until the
               // next EXEC.
               if (out_ready) begin
                  if (in_valid) begin
                     a_q     <= in_a;
                     b_q     <= in_b;
                     op_q    <= in_op;
                     state_q <= EXEC;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Directed bench for alu_op_sequencer. The driver pushes each request's
//   hand-computed {err, zero, res} into exp_q when the request is accepted. The
//   monitor pops and compares on every result handoff, and it also checks
//   op_count against its own count.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;
   localparam int EXP_W = WIDTH + 2;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_res;
   logic             out_zero;
   logic             out_err;
   logic [CNT_W-1:0] op_count;
   state_t           dbg_state;

   logic [EXP_W-1:0] exp_q[$];
   logic [CNT_W-1:0] exp_count;
   int               n_cmp;
   int               n_fail;

   alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_zero  (out_zero),
      .out_err   (out_err),
      .op_count  (op_count),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // The driver holds the request until it is accepted, then returns 1 ns after
   // the accepting edge. exp is {err, zero, res}.
   task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [EXP_W-1:0] exp);
      bit accepted;
      accepted = 1'b0;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !accepted; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(exp);
            @(posedge clk);
            #1;
            accepted = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!accepted) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: request op=%0d not accepted in 50 cycles", op);
      end
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < 100) begin
         @(posedge clk);
         i++;
      end
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got res=0x%0h with no pending request", out_res);
         end else begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            check("result_res",  32'(out_res),  32'(e[WIDTH-1:0]));
            check("result_zero", 32'(out_zero), 32'(e[WIDTH]));
            check("result_err",  32'(out_err),  32'(e[WIDTH+1]));
         end
         check("op_count_at_handoff", 32'(op_count), 32'(exp_count));
         exp_count = exp_count + CNT_W'(1);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      exp_count = '0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_op     = '0;
      out_ready = 1'b1;
      rst       = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_res",   32'(out_res),   32'd0);
      check("reset_out_zero",  32'(out_zero),  32'd0);
      check("reset_out_err",   32'(out_err),   32'd0);
      check("reset_op_count",  32'(op_count),  32'd0);
      check("reset_in_ready",  32'(in_ready),  32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // NOT with a latency check: EXEC after the accept edge, DONE one edge later.
      issue(4'd6, 4'd0, OP_NOT, {1'b0, 1'b0, 4'd9});
      check("lat_exec_valid", 32'(out_valid), 32'd0);
      check("lat_exec_state", 32'(dbg_state), 32'(EXEC));
      @(posedge clk);
      #1;
      check("lat_done_valid", 32'(out_valid), 32'd1);

      issue(4'd6,  4'd3,  OP_AND,  {1'b0, 1'b0, 4'd2});
      issue(4'd6,  4'd3,  OP_OR,   {1'b0, 1'b0, 4'd7});
      issue(4'd15, 4'd15, OP_NAND, {1'b0, 1'b1, 4'd0});
      issue(4'd5,  4'd5,  OP_XOR,  {1'b0, 1'b1, 4'd0});
      issue(4'd9,  4'd4,  3'b111,  {1'b1, 1'b1, 4'd0});
      drain();
      check("count_after_six", 32'(op_count), 32'd6);

      // Backpressure: the result must stay put and in_ready must stay low.
      out_ready = 1'b0;
      issue(4'd10, 4'd12, OP_OR, {1'b0, 1'b0, 4'd14});
      for (int i = 0; i < 10 && !out_valid; i++) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_res",   32'(out_res),   32'd14);
         check("bp_out_zero",  32'(out_zero),  32'd0);
         check("bp_in_ready",  32'(in_ready),  32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      issue(4'd6, 4'd3, OP_AND, {1'b0, 1'b0, 4'd2});
      check("bp_b2b_count", 32'(op_count), 32'd7);
      check("bp_b2b_state", 32'(dbg_state), 32'(EXEC));
      drain();

      // Reset in the middle of EXEC discards the operation.
      issue(4'd9, 4'd9, OP_AND, {1'b0, 1'b0, 4'd9});
      check("rst_pre_state", 32'(dbg_state), 32'(EXEC));
      rst = 1'b1;
      exp_q.delete();
      exp_count = '0;
      #1;
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_count", 32'(op_count),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_rel_in_ready", 32'(in_ready),  32'd1);
      check("rst_rel_state",    32'(dbg_state), 32'(IDLE));
      @(posedge clk);
      #1;

      // 256 handoffs from reset: the counter wraps back to 0.
      for (int i = 0; i < 256; i++) begin
         logic [3:0] v;
         v = 4'(i);
         issue(v, 4'hF, OP_AND, {1'b0, (v == 4'd0), v});
      end
      drain();
      check("wrap_count", 32'(op_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
